eclk_bus_sync: RTL and testbench

ECLK_BUS_SYNC -- requirements
Module: eclk_bus_sync

---
 rtl/eclk_bus_sync.sv | 159 +++++++++++++++
 tb/tb_eclk_bus_sync.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/eclk_bus_sync.sv
// eclk_bus_sync: 6800-style synchronous peripheral cycle sequencer.
// The E-clock phase is supplied as a one-hot ten-slot vector that advances on
// every 7 MHz enable. A requested cycle waits for the VMA slot, runs through
// the E-high phase, strobes data at slot 9 and acknowledges at slot 0.
// A corrupted phase vector sets a sticky error flag. If the address is already
// valid, the cycle is wound up at the next clean slot 0.
module eclk_bus_sync #(
  parameter int VMA_SLOT    = 3,
  parameter int E_RISE_SLOT = 6
) (
  input  logic       clk_28,
  input  logic       reset_n,
  input  logic       clk7_en,
  input  logic [9:0] eclk,
  input  logic       req,
  input  logic       rw,
  output logic       e_out,
  output logic       vma,
  output logic       strb,
  output logic       rw_q,
  output logic       ack,
  output logic       busy,
  output logic       err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_VMA,
    S_ACCESS,
    S_DONE
  } state_t;

  state_t state;
  state_t state_nx;

  // Phase qualification. An all-zero vector stalls the sequence. A multi-hot
  // vector is treated as a lost phase.
  logic phase_ok;
  logic phase_zero;
  logic phase_multi;
  logic e_nx;

  // One-cycle control events decoded from the state machine
  logic accept;
  logic abort;
  logic vma_set;
  logic strb_set;
  logic finish;

  assign phase_ok    = $onehot(eclk);
  assign phase_zero  = (eclk == 10'd0);
  assign phase_multi = !phase_ok && !phase_zero;
  assign e_nx        = |eclk[9:E_RISE_SLOT];

  // State register, asynchronously cleared to idle
  always_ff @(posedge clk_28 or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state decode. Transitions are taken only on 7 MHz enable cycles.
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    abort    = 1'b0;
    vma_set  = 1'b0;
    strb_set = 1'b0;
    finish   = 1'b0;
    if (clk7_en) begin
      unique case (state)
        S_IDLE: begin
          if (req) begin
            state_nx = S_SYNC;
            accept   = 1'b1;
          end
        end
        S_SYNC: begin
          // Until the address is valid, a withdrawn request simply cancels.
          if (!req) begin
            state_nx = S_IDLE;
            abort    = 1'b1;
          end else if (phase_ok && eclk[VMA_SLOT]) begin
            state_nx = S_VMA;
            vma_set  = 1'b1;
          end
        end
        S_VMA: begin
          // Once VMA is out, the request level is no longer consulted.
          if (phase_multi) begin
            state_nx = S_DONE;
          end else if (phase_ok && eclk[E_RISE_SLOT]) begin
            state_nx = S_ACCESS;
          end
        end
        S_ACCESS: begin
          // A lost phase skips the strobe but still closes the cycle.
          if (phase_multi) begin
            state_nx = S_DONE;
          end else if (phase_ok && eclk[9]) begin
            state_nx = S_DONE;
            strb_set = 1'b1;
          end
        end
        S_DONE: begin
          if (phase_ok && eclk[0]) begin
            state_nx = S_IDLE;
            finish   = 1'b1;
          end
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  // Output registers. strb and ack self-clear on the following clk_28 edge.
  always_ff @(posedge clk_28 or negedge reset_n) begin
    if (!reset_n) begin
      e_out <= 1'b0;
      vma   <= 1'b0;
      strb  <= 1'b0;
      rw_q  <= 1'b0;
      ack   <= 1'b0;
      busy  <= 1'b0;
      err   <= 1'b0;
    end else begin
      strb <= 1'b0;
      ack  <= 1'b0;
      if (clk7_en) begin
        e_out <= e_nx;
        if (!phase_ok) begin
          err <= 1'b1;
        end
        if (accept) begin
          rw_q <= rw;
          busy <= 1'b1;
        end
        if (abort) begin
          busy <= 1'b0;
        end
        if (vma_set) begin
          vma <= 1'b1;
        end
        if (strb_set) begin
          strb <= 1'b1;
        end
        if (finish) begin
          vma  <= 1'b0;
          ack  <= 1'b1;
          busy <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_eclk_bus_sync.sv
// tb_eclk_bus_sync: directed bench for the E-clock synchronous cycle sequencer.
module tb_eclk_bus_sync;

  logic       clk_28  = 1'b0;
  logic       reset_n = 1'b0;
  logic       clk7_en = 1'b0;
  logic [9:0] eclk    = 10'd1;
  logic       req     = 1'b0;
  logic       rw      = 1'b0;
  logic       e_out, vma, strb, rw_q, ack, busy, err;

  int checks = 0;
  int errors = 0;

  // slot: next E slot to present; cur: slot presented by the last step (-1 = forced)
  int slot = 0;
  int cur  = 0;

  logic s_e, s_vma, s_strb, s_rwq, s_ack, s_busy, s_err;
  int   wide_cnt    = 0;
  int   overlap_cnt = 0;

  always #5 clk_28 = ~clk_28;

  eclk_bus_sync #(
    .VMA_SLOT   (3),
    .E_RISE_SLOT(6)
  ) dut (
    .clk_28 (clk_28),
    .reset_n(reset_n),
    .clk7_en(clk7_en),
    .eclk   (eclk),
    .req    (req),
    .rw     (rw),
    .e_out  (e_out),
    .vma    (vma),
    .strb   (strb),
    .rw_q   (rw_q),
    .ack    (ack),
    .busy   (busy),
    .err    (err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One 7 MHz period (four clk_28 cycles): enable on the first, outputs
  // sampled one and two clk_28 cycles after the enable edge.
  task automatic drive(input logic [9:0] v, input bit advance);
    @(negedge clk_28);
    clk7_en = 1'b1;
    eclk    = v;
    @(negedge clk_28);
    clk7_en = 1'b0;
    {s_e, s_vma, s_strb, s_rwq, s_ack, s_busy, s_err} = {e_out, vma, strb, rw_q, ack, busy, err};
    if (s_strb && s_ack) overlap_cnt++;
    @(negedge clk_28);
    if (strb || ack) wide_cnt++;
    @(negedge clk_28);
    if (advance) begin
      cur  = slot;
      slot = (slot == 9) ? 0 : slot + 1;
    end else begin
      cur = -1;
    end
  endtask

  task automatic step7();
    logic [9:0] one;
    one = 10'd1;
    drive(one << slot, 1'b1);
  endtask

  task automatic run_to(input int s);
    while (slot != s) step7();
  endtask

  logic [5:0] exp_a [10];
  int n, m, acks, last, strbs;
  logic seen;

  initial begin
    // {vma, e_out, strb, ack, busy, rw_q} for slots 1..9, 0 of a read cycle
    exp_a = '{6'b000011, 6'b000011, 6'b100011, 6'b100011, 6'b100011,
              6'b110011, 6'b110011, 6'b110011, 6'b111011, 6'b000101};

    // Reset state
    repeat (3) @(negedge clk_28);
    check("reset_outputs", {e_out, vma, strb, rw_q, ack, busy, err}, 7'd0);
    reset_n = 1'b1;

    // Read cycle requested at slot 1
    run_to(1);
    req = 1'b1;
    rw  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step7();
      if (i == 0) rw = 1'b0;
      if (i == 2) req = 1'b0;
      check($sformatf("a_slot%0d", cur), {s_vma, s_e, s_strb, s_ack, s_busy, s_rwq}, exp_a[i]);
    end

    // Write cycle requested at slot 4: waits for the following slot 3
    run_to(4);
    req = 1'b1;
    rw  = 1'b0;
    step7();
    check("b_accept", {s_busy, s_rwq, s_vma}, 3'b100);
    n = 0;
    s_vma = 1'b0;
    while (!s_vma && n < 20) begin
      step7();
      n++;
    end
    check("b_vma_delay", n, 9);
    req = 1'b0;
    m = 0;
    s_ack = 1'b0;
    while (!s_ack && m < 20) begin
      step7();
      m++;
    end
    check("b_vma_to_ack", m, 7);
    check("b_ack_slot", cur, 0);

    // Request withdrawn before the VMA slot
    run_to(0);
    req = 1'b1;
    step7();
    check("c_accept_busy", s_busy, 1'b1);
    seen = 1'b0;
    step7();
    seen = seen | s_vma | s_ack;
    req = 1'b0;
    step7();
    check("c_abort_busy", s_busy, 1'b0);
    seen = seen | s_vma | s_ack;
    for (int i = 0; i < 10; i++) begin
      step7();
      seen = seen | s_vma | s_ack | s_busy | s_strb;
    end
    check("c_no_cycle", seen, 1'b0);

    // Request held continuously: one cycle per E period
    run_to(1);
    req  = 1'b1;
    rw   = 1'b1;
    acks = 0;
    last = -1;
    for (int i = 0; i < 30; i++) begin
      step7();
      if (s_ack) begin
        acks++;
        if (last >= 0) check("d_ack_spacing", i - last, 10);
        last = i;
      end
    end
    req = 1'b0;
    check("d_ack_count", acks, 3);
    check("d_last_ack", last, 29);

    // Multi-hot phase while VMA is asserted
    run_to(1);
    req = 1'b1;
    rw  = 1'b0;
    repeat (3) step7();
    check("e_vma_up", s_vma, 1'b1);
    req = 1'b0;
    drive(10'b0000000011, 1'b0);
    check("e_err_vma", {s_err, s_vma}, 2'b11);
    strbs = 0;
    m = 0;
    s_ack = 1'b0;
    while (!s_ack && m < 15) begin
      step7();
      m++;
      if (s_strb) strbs++;
    end
    check("e_ack_slot", cur, 0);
    check("e_no_strb", strbs, 0);
    check("e_after_ack", {s_vma, s_busy, s_err}, 3'b001);
    step7();
    check("e_err_sticky", s_err, 1'b1);

    // Reset asserted during the access phase
    run_to(1);
    req = 1'b1;
    repeat (6) step7();
    check("g_pre_reset", {vma, busy, err}, 3'b111);
    #3 reset_n = 1'b0;
    #1 check("g_async_clear", {e_out, vma, strb, rw_q, ack, busy, err}, 7'd0);
    req = 1'b0;
    repeat (2) @(negedge clk_28);
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      step7();
      seen = seen | s_strb | s_ack | s_vma | s_busy;
    end
    check("g_no_pulses", seen, 1'b0);

    // First request after reset: minimum-latency cycle from slot 2
    run_to(2);
    req = 1'b1;
    step7();
    n = 0;
    s_ack = 1'b0;
    while (!s_ack && n < 20) begin
      step7();
      n++;
      if (n == 1) begin
        check("g_restart_vma", s_vma, 1'b1);
        req = 1'b0;
      end
    end
    check("g_min_latency", n, 8);

    // All-zero phase stalls the VMA state without ending the cycle
    run_to(1);
    req = 1'b1;
    repeat (3) step7();
    req = 1'b0;
    repeat (3) drive(10'd0, 1'b0);
    check("f_zero_hold", {s_err, s_vma, s_busy}, 3'b111);
    strbs = 0;
    m = 0;
    s_ack = 1'b0;
    while (!s_ack && m < 15) begin
      step7();
      m++;
      if (s_strb) begin
        strbs++;
        check("f_strb_slot", cur, 9);
      end
    end
    check("f_strb_count", strbs, 1);
    check("f_ack_slot", cur, 0);

    check("pulse_width", wide_cnt, 0);
    check("strb_ack_overlap", overlap_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
